// File: rtl/exc_commit.sv
// Memory-stage exception commit: prioritises NMI, interrupt and pipeline sources,
// reports one record to CP0 over valid/ready, then holds a pipeline flush.
module exc_commit #(
    parameter int unsigned          NSRC         = 18,
    parameter int unsigned          TW           = 5,
    parameter int unsigned          AW           = 32,
    parameter int unsigned          NHW          = 6,
    parameter int unsigned          SYNC         = 2,
    parameter int unsigned          FLUSH_CYCLES = 2,
    parameter logic [NSRC*TW-1:0]   TYPE_MAP     = '0,
    parameter logic [2*NSRC-1:0]    BADDR_SEL    = '0,
    parameter logic [TW-1:0]        TYPE_NMI     = '0,
    parameter logic [TW-1:0]        TYPE_INTR    = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NSRC-1:0] src,
    input  logic            inst_valid,
    input  logic            in_bd,
    input  logic            mem_stall,
    input  logic [AW-1:0]   pc,
    input  logic [AW-1:0]   m_vaddr,
    input  logic [31:0]     cp0_Status,
    input  logic [31:0]     cp0_Cause,
    input  logic [NHW-1:0]  irq,
    input  logic            nmi,
    input  logic            exc_ready,
    output logic            exc_valid,
    output logic [TW-1:0]   exc_type,
    output logic [AW-1:0]   exc_epc,
    output logic            exc_bd,
    output logic [AW-1:0]   exc_baddr,
    output logic            exc_flush,
    output logic [5:0]      ip_hw
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REPORT = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [NHW-1:0]  irq_sync [SYNC];
    logic [SYNC-1:0] nmi_sync;
    logic            nmi_prev;
    logic            nmi_pend;
    logic            nmi_rise;
    logic            intr;
    logic            take;
    logic [7:0]      ip_all;
    logic [TW-1:0]   win_type;
    logic [AW-1:0]   win_baddr;
    logic            unused_bits;

    assign unused_bits = ^{cp0_Status[31:16], cp0_Status[7:3], cp0_Cause[31:10], cp0_Cause[7:0]};

    // Two-or-more flop synchronisers for the asynchronous irq/nmi levels
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(SYNC); i++) begin
                irq_sync[i] <= '0;
            end
            nmi_sync <= '0;
            nmi_prev <= 1'b0;
        end else begin
            irq_sync[0] <= irq;
            for (int i = 1; i < int'(SYNC); i++) begin
                irq_sync[i] <= irq_sync[i-1];
            end
            nmi_sync <= {nmi_sync[SYNC-2:0], nmi};
            nmi_prev <= nmi_sync[SYNC-1];
        end
    end

    assign ip_hw    = 6'(irq_sync[SYNC-1]);
    assign nmi_rise = nmi_sync[SYNC-1] & ~nmi_prev;

    assign ip_all = {ip_hw, cp0_Cause[9:8]};
    assign intr   = (|(ip_all & cp0_Status[15:8])) & cp0_Status[0]
                    & ~cp0_Status[1] & ~cp0_Status[2];

    assign take = (state == S_IDLE) & inst_valid & ~mem_stall & (nmi_pend | intr | (|src));

    // Pending NMI: a new edge wins over the clear from a simultaneous capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            nmi_pend <= 1'b0;
        end else begin
            nmi_pend <= nmi_rise | (nmi_pend & ~take);
        end
    end

    // Winner selection: lowest src index wins, interrupt and NMI override
    always_comb begin
        win_type  = '0;
        win_baddr = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (src[i]) begin
                win_type = TYPE_MAP[i*TW +: TW];
                case (BADDR_SEL[2*i +: 2])
                    2'd1:    win_baddr = pc;
                    2'd2:    win_baddr = m_vaddr;
                    default: win_baddr = '0;
                endcase
            end
        end
        if (intr) begin
            win_type  = TYPE_INTR;
            win_baddr = '0;
        end
        if (nmi_pend) begin
            win_type  = TYPE_NMI;
            win_baddr = '0;
        end
    end

    // Commit FSM with registered record and flush outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            exc_valid <= 1'b0;
            exc_flush <= 1'b0;
            exc_type  <= '0;
            exc_epc   <= '0;
            exc_bd    <= 1'b0;
            exc_baddr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        state     <= S_REPORT;
                        exc_valid <= 1'b1;
                        exc_flush <= 1'b1;
                        exc_type  <= win_type;
                        exc_epc   <= in_bd ? (pc - AW'(4)) : pc;
                        exc_bd    <= in_bd;
                        exc_baddr <= win_baddr;
                    end
                end
                S_REPORT: begin
                    if (exc_ready) begin
                        exc_valid <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state     <= S_IDLE;
                            exc_flush <= 1'b0;
                        end else begin
                            state <= S_FLUSH;
                            cnt   <= CW'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (cnt == '0) begin
                        state     <= S_IDLE;
                        exc_flush <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    exc_valid <= 1'b0;
                    exc_flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit.sv
// Randomised bench for exc_commit: a cycle-level behavioural model (queues and
// counters) is compared against every output after every clock edge.
module tb_exc_commit;

    localparam int unsigned NSRC = 8;
    localparam int unsigned TW   = 5;
    localparam int unsigned AW   = 32;
    localparam int unsigned NHW  = 6;
    localparam int unsigned SYNC = 2;
    localparam int unsigned FC   = 2;
    localparam logic [NSRC*TW-1:0] TMAP = {5'h10, 5'h0F, 5'h0E, 5'h0D, 5'h0C, 5'h0B, 5'h0A, 5'h09};
    localparam logic [2*NSRC-1:0]  BSEL = {2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    localparam logic [TW-1:0] T_NMI  = 5'h1E;
    localparam logic [TW-1:0] T_INTR = 5'h01;

    logic            clk;
    logic            resetn;
    logic [NSRC-1:0] src;
    logic            inst_valid, in_bd, mem_stall;
    logic [AW-1:0]   pc, m_vaddr;
    logic [31:0]     status, cause;
    logic [NHW-1:0]  irq;
    logic            nmi, exc_ready;
    logic            exc_valid, exc_bd, exc_flush;
    logic [TW-1:0]   exc_type;
    logic [AW-1:0]   exc_epc, exc_baddr;
    logic [5:0]      ip_hw;

    int checks = 0;
    int errors = 0;

    exc_commit #(
        .NSRC(NSRC), .TW(TW), .AW(AW), .NHW(NHW), .SYNC(SYNC), .FLUSH_CYCLES(FC),
        .TYPE_MAP(TMAP), .BADDR_SEL(BSEL), .TYPE_NMI(T_NMI), .TYPE_INTR(T_INTR)
    ) dut (
        .clk(clk), .resetn(resetn), .src(src), .inst_valid(inst_valid), .in_bd(in_bd),
        .mem_stall(mem_stall), .pc(pc), .m_vaddr(m_vaddr), .cp0_Status(status),
        .cp0_Cause(cause), .irq(irq), .nmi(nmi), .exc_ready(exc_ready),
        .exc_valid(exc_valid), .exc_type(exc_type), .exc_epc(exc_epc), .exc_bd(exc_bd),
        .exc_baddr(exc_baddr), .exc_flush(exc_flush), .ip_hw(ip_hw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic            m_valid, m_flush, m_bd, m_pend, m_nmi_s, m_nmi_prev;
    int              m_left;
    logic [TW-1:0]   m_type;
    logic [AW-1:0]   m_epc, m_baddr;
    logic [5:0]      m_ip;
    logic [NHW-1:0]  irq_q[$];
    logic            nmi_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_flush = 0; m_bd = 0; m_pend = 0; m_nmi_s = 0; m_nmi_prev = 0;
        m_left = 0; m_type = '0; m_epc = '0; m_baddr = '0; m_ip = '0;
        irq_q.delete();
        nmi_q.delete();
        for (int i = 0; i < int'(SYNC) - 1; i++) begin
            irq_q.push_back('0);
            nmi_q.push_back(1'b0);
        end
    endtask

    // One clock edge of the model, evaluated from the pre-edge inputs
    task automatic model_step();
        logic intr, rise, take, old_pend;
        logic [7:0] ipv;
        int sel;
        if (!resetn) begin
            model_reset();
            return;
        end
        ipv      = {m_ip, cause[9:8]};
        intr     = ((ipv & status[15:8]) != 0) && status[0] && !status[1] && !status[2];
        rise     = m_nmi_s && !m_nmi_prev;
        old_pend = m_pend;
        take     = !m_flush && inst_valid && !mem_stall && (old_pend || intr || src != 0);
        if (take) begin
            m_valid = 1; m_flush = 1; m_bd = in_bd;
            m_epc = in_bd ? pc - 32'd4 : pc;
            if (old_pend) begin
                m_type = T_NMI; m_baddr = '0;
            end else if (intr) begin
                m_type = T_INTR; m_baddr = '0;
            end else begin
                for (int i = 0; i < int'(NSRC); i++) begin
                    if (src[i]) begin
                        m_type = TW'(9 + i);
                        sel = (i + 3) % 4;
                        m_baddr = (sel == 1) ? pc : (sel == 2) ? m_vaddr : '0;
                        break;
                    end
                end
            end
        end else if (m_valid) begin
            if (exc_ready) begin
                m_valid = 0;
                m_left  = FC;
                if (m_left == 0) m_flush = 0;
            end
        end else if (m_flush) begin
            m_left--;
            if (m_left == 0) m_flush = 0;
        end
        m_pend = rise || (old_pend && !take);
        irq_q.push_back(irq);
        m_ip = 6'(irq_q.pop_front());
        m_nmi_prev = m_nmi_s;
        nmi_q.push_back(nmi);
        m_nmi_s = nmi_q.pop_front();
    endtask

    task automatic compare_all();
        chk("exc_valid", exc_valid, m_valid);
        chk("exc_flush", exc_flush, m_flush);
        chk("exc_type",  exc_type,  m_type);
        chk("exc_epc",   exc_epc,   m_epc);
        chk("exc_bd",    exc_bd,    m_bd);
        chk("exc_baddr", exc_baddr, m_baddr);
        chk("ip_hw",     ip_hw,     m_ip);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic quiet();
        src = '0; inst_valid = 0; in_bd = 0; mem_stall = 0; pc = '0; m_vaddr = '0;
        status = '0; cause = '0; irq = '0; nmi = 0; exc_ready = 1;
    endtask

    task automatic async_reset();
        resetn = 0;
        #1;
        model_reset();
        compare_all();
        chk("rst_valid", exc_valid, 1'b0);
        chk("rst_flush", exc_flush, 1'b0);
        #1;
        resetn = 1;
    endtask

    initial begin
        quiet();
        resetn = 0;
        model_reset();
        cycles(3);
        chk("reset_valid", exc_valid, 1'b0);
        chk("reset_flush", exc_flush, 1'b0);
        chk("reset_ip", ip_hw, 6'h0);
        resetn = 1;
        cycle();

        // Single source with vaddr as bad address
        src = 8'h08; inst_valid = 1; pc = 32'h8000_1000; m_vaddr = 32'h1234;
        cycle();
        chk("single_valid", exc_valid, 1'b1);
        chk("single_type", exc_type, 5'h0C);
        chk("single_epc", exc_epc, 32'h8000_1000);
        chk("single_baddr", exc_baddr, 32'h1234);
        src = '0; inst_valid = 0;
        cycle();
        chk("single_drop", exc_valid, 1'b0);
        chk("single_fl1", exc_flush, 1'b1);
        cycle();
        chk("single_fl2", exc_flush, 1'b1);
        cycle();
        chk("single_fl_end", exc_flush, 1'b0);

        // Interrupt beats sources, delay slot EPC
        status = 32'h0000_0401; irq = 6'h01;
        cycle();
        chk("ip_sync_1", ip_hw, 6'h00);
        cycle();
        chk("ip_sync_2", ip_hw, 6'h01);
        inst_valid = 1; in_bd = 1; pc = 32'h100; src = 8'h21;
        cycle();
        chk("prio_type", exc_type, T_INTR);
        chk("prio_epc", exc_epc, 32'hFC);
        chk("prio_bd", exc_bd, 1'b1);
        chk("prio_baddr", exc_baddr, 32'h0);
        quiet();
        cycles(4);

        // Interrupt gating by IE/EXL/ERL and synchroniser latency
        irq = 6'h04; inst_valid = 1; pc = 32'h200; status = 32'h0000_1000;
        cycles(3);
        chk("gate_ie0", exc_valid, 1'b0);
        status = 32'h0000_1003;
        cycles(2);
        chk("gate_exl", exc_valid, 1'b0);
        status = 32'h0000_1005;
        cycles(2);
        chk("gate_erl", exc_valid, 1'b0);
        irq = 6'h00;
        cycles(3);
        status = 32'h0000_1001; irq = 6'h04;
        cycle();
        chk("sync_lat1", exc_valid, 1'b0);
        cycle();
        chk("sync_lat2", exc_valid, 1'b0);
        cycle();
        chk("sync_take", exc_valid, 1'b1);
        chk("sync_type", exc_type, T_INTR);
        quiet();
        cycles(5);

        // NMI held pending across a stall, second edge during a stalled handshake
        inst_valid = 1; mem_stall = 1; pc = 32'h300; nmi = 1;
        cycle();
        nmi = 0;
        cycles(4);
        chk("nmi_stalled", exc_valid, 1'b0);
        mem_stall = 0; exc_ready = 0;
        cycle();
        chk("nmi_take", exc_valid, 1'b1);
        chk("nmi_type", exc_type, T_NMI);
        nmi = 1; src = 8'h02;
        cycle();
        nmi = 0; src = 8'h80;
        cycles(3);
        chk("hs_valid", exc_valid, 1'b1);
        chk("hs_type", exc_type, T_NMI);
        chk("hs_flush", exc_flush, 1'b1);
        exc_ready = 1; src = '0; pc = 32'h304;
        cycles(3);
        chk("nmi2_idle", exc_flush, 1'b0);
        cycle();
        chk("nmi2_take", exc_valid, 1'b1);
        chk("nmi2_epc", exc_epc, 32'h304);
        quiet();
        cycles(4);

        // Asynchronous reset inside FLUSH, then a normal take
        src = 8'h01; inst_valid = 1; pc = 32'h400;
        cycle();
        src = '0; inst_valid = 0;
        cycle();
        async_reset();
        chk("rst_type", exc_type, 5'h0);
        chk("rst_epc", exc_epc, 32'h0);
        src = 8'h04; inst_valid = 1; pc = 32'h2000;
        cycle();
        chk("post_rst_valid", exc_valid, 1'b1);
        chk("post_rst_type", exc_type, 5'h0B);
        chk("post_rst_baddr", exc_baddr, 32'h2000);
        quiet();
        cycles(4);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            src        = ($urandom_range(0, 2) == 0) ? NSRC'($urandom) : '0;
            inst_valid = ($urandom_range(0, 3) != 0);
            mem_stall  = ($urandom_range(0, 3) == 0);
            in_bd      = 1'($urandom);
            pc         = $urandom & 32'hFFFF_FFFC;
            m_vaddr    = $urandom;
            status     = $urandom;
            if ($urandom_range(0, 1) == 0) status = (status & 32'hFFFF_FFF8) | 32'h1;
            cause      = $urandom;
            if ($urandom_range(0, 5) == 0) irq = NHW'($urandom);
            if ($urandom_range(0, 7) == 0) nmi = ~nmi;
            exc_ready  = ($urandom_range(0, 4) < 3);
            cycle();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
